// File: rtl/m_alu_iter.sv
// Iterative RV32M/RV64M execution unit: registered multiply, XLEN-step restoring
// divider, RISC-V corner-case fast paths and a DIV/REM fusion cache.
module m_alu_iter #(
    parameter int XLEN    = 32,
    parameter bit FUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_PREP, S_DIV_ITER, S_DIV_FIX, S_DONE
    } state_t;

    state_t          state_q;
    logic            in_ready_q, out_valid_q;
    logic [XLEN-1:0] out_result_q, res_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] divisor_q, quo_q, rem_q;
    logic            neg_q_q, neg_r_q;
    logic [CW-1:0]   cnt_q;
    logic            cache_valid_q, cache_signed_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

    // Request classification at the accept edge
    logic            accept, in_signed, b_zero, sovf, special, fuse_hit;
    logic [XLEN-1:0] special_res;
    always_comb begin
        accept      = in_valid && in_ready_q && !flush;
        in_signed   = ~in_op[0];
        b_zero      = (in_b == '0);
        sovf        = in_signed && (in_a == MIN_INT) && (in_b == ALL_ONES);
        special     = in_op[2] && (b_zero || sovf);
        special_res = '0;
        if (b_zero)
            special_res = in_op[1] ? in_a : ALL_ONES;
        else
            special_res = in_op[1] ? '0 : MIN_INT;
        fuse_hit = FUSE_EN && cache_valid_q && in_op[2] && !special
                   && (in_a == cache_a_q) && (in_b == cache_b_q)
                   && (in_signed == cache_signed_q);
    end

    // Low 2*XLEN bits of the sign/zero-extended product are exact for every variant
    logic                mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0]   ext_a, ext_b, prod;
    logic [XLEN-1:0]     mul_res;
    always_comb begin
        mul_a_sgn = (op_q[1:0] != 2'd3);
        mul_b_sgn = ~op_q[1];
        ext_a     = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
        ext_b     = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
        prod      = ext_a * ext_b;
        mul_res   = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            div_signed;
    logic [XLEN-1:0] abs_a, abs_b, rem_d, quo_d, q_fix, r_fix;
    logic [XLEN:0]   rem_shift, diff;
    always_comb begin
        div_signed = ~op_q[0];
        abs_a      = (div_signed && a_q[XLEN-1]) ? -a_q : a_q;
        abs_b      = (div_signed && b_q[XLEN-1]) ? -b_q : b_q;
        rem_shift  = {rem_q, quo_q[XLEN-1]};
        diff       = rem_shift - {1'b0, divisor_q};
        if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        q_fix = neg_q_q ? -quo_q : quo_q;
        r_fix = neg_r_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            res_q         <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            divisor_q     <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            cnt_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_signed_q<= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
        end else if (flush && state_q != S_IDLE) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= in_op;
                        a_q        <= in_a;
                        b_q        <= in_b;
                        in_ready_q <= 1'b0;
                        if (!in_op[2]) begin
                            state_q <= S_MUL;
                        end else if (special) begin
                            res_q         <= special_res;
                            cache_valid_q <= 1'b0;
                            state_q       <= S_DONE;
                        end else if (fuse_hit) begin
                            res_q   <= in_op[1] ? cache_rem_q : cache_quo_q;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DIV_PREP;
                        end
                    end
                end
                S_MUL: begin
                    res_q   <= mul_res;
                    state_q <= S_DONE;
                end
                S_DIV_PREP: begin
                    divisor_q <= abs_b;
                    quo_q     <= abs_a;
                    rem_q     <= '0;
                    neg_q_q   <= div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_r_q   <= div_signed && a_q[XLEN-1];
                    cnt_q     <= CW'(XLEN-1);
                    state_q   <= S_DIV_ITER;
                end
                S_DIV_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0)
                        state_q <= S_DIV_FIX;
                    else
                        cnt_q <= cnt_q - CW'(1);
                end
                S_DIV_FIX: begin
                    res_q          <= op_q[1] ? r_fix : q_fix;
                    cache_valid_q  <= FUSE_EN;
                    cache_signed_q <= div_signed;
                    cache_a_q      <= a_q;
                    cache_b_q      <= b_q;
                    cache_quo_q    <= q_fix;
                    cache_rem_q    <= r_fix;
                    state_q        <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; it then holds until taken
                    if (!out_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= res_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_m_alu_iter.sv
// Scoreboard bench for m_alu_iter (XLEN=32): directed vectors, result and
// accept-to-valid latency checked by an independent output monitor.
module tb_m_alu_iter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a, in_b, out_result;

    always #5 clk = ~clk;

    m_alu_iter #(.XLEN(XLEN), .FUSE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    // Output monitor: first valid cycle checks result/latency, held cycles check stability
    logic        held = 1'b0;
    logic [31:0] held_val;
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!held) begin
                    held = 1'b1;
                    if (sb.size() == 0) begin
                        check("unexpected_output", out_result, 32'hDEAD_BEEF);
                        held_val = out_result;
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check({e.name, "_result"}, out_result, e.res);
                        check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                        $display("txn %s result=0x%08h latency=%0d", e.name, out_result, cyc - e.acc);
                        held_val = e.res;
                    end
                end else begin
                    check("held_result_stable", out_result, held_val);
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("busy_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat,
                         input bit expect_out);
        wait_ready();
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom());
        in_a     = $urandom();
        in_b     = $urandom();
        if (expect_out) sb.push_back('{name, res, lat, cyc});
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
        issue(name, op, a, b, res, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("MULH_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run("MUL_m1_m1",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        run("MULHSU_m1_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run("MULHU_max_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run("DIV_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35);
        run("REM_m7_2_fused",3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1);
        run("DIVU_7_0",      3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        run("REMU_7_0",      3'd7, 32'd7,         32'd0,         32'd7,         1);
        run("DIV_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("REM_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush in the tenth iteration cycle: the result must never appear
        issue("DIVU_flushed", 3'd5, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_no_output", {31'b0, out_valid}, 32'd0);

        // Flush and request together in IDLE: request is dropped
        in_op = 3'd0; in_a = 32'd2; in_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_beats_valid", {31'b0, busy}, 32'd0);
        @(negedge clk);

        run("REMU_100_7",       3'd7, 32'd100, 32'd7,         32'd2,         35);
        run("DIVU_100_7_fused", 3'd5, 32'd100, 32'd7,         32'd14,        1);
        run("DIV_100_m7",       3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 35);
        run("REM_100_m7_fused", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2,         1);

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        issue("MUL_3_5_bp", 3'd0, 32'd3, 32'd5, 32'd15, 2, 1'b1);
        begin
            int n = 0;
            while (out_valid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_result", out_result, 32'd15);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_done_in_ready", {31'b0, in_ready}, 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
